// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  localparam int DMEM_ADDR_WIDTH = 17;
  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_CNT_WIDTH  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } dmem_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } dmem_owner_t;

  // The requester that did not win last time; used to break ties.
  function automatic dmem_owner_t other_owner(input dmem_owner_t own);
    dmem_owner_t res;
    if (own == OWN_CPU) begin
      res = OWN_LDR;
    end else begin
      res = OWN_CPU;
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/done handshake bundle between one requester and the arbiter.
interface dmem_arbiter_if;
  import dmem_pkg::*;

  logic                       req;
  logic                       we;
  logic [DMEM_DATA_WIDTH-1:0] addr;
  logic [DMEM_DATA_WIDTH-1:0] wdata;
  logic                       done;
  logic [DMEM_DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input done, rdata);
  modport slave  (input req, we, addr, wdata, output done, rdata);

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant, last winner
// remembered only when the grant is actually accepted.
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_cpu,
  input  logic        req_ldr,
  input  logic        accept,
  output dmem_owner_t grant,
  output logic        any_req
);

  dmem_owner_t last_grant_r;

  // Pick a winner; on a tie the requester that lost last time goes first.
  always_comb begin
    any_req = req_cpu | req_ldr;
    grant   = OWN_CPU;
    if (req_cpu && req_ldr) begin
      grant = other_owner(last_grant_r);
    end else if (req_ldr) begin
      grant = OWN_LDR;
    end else begin
      grant = OWN_CPU;
    end
  end

  // Remember the accepted winner; LDR after reset so the cpu wins the first tie.
  always_ff @(posedge CLK) begin
    if (reset) begin
      last_grant_r <= OWN_LDR;
    end else if (accept) begin
      last_grant_r <= grant;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipeline memory stage
// and the UART loader, sequencing each access over the fixed read latency.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = DMEM_ADDR_WIDTH,
  parameter int MEM_LATENCY = 2
) (
  input  logic                       CLK,
  input  logic                       reset,
  dmem_arbiter_if.slave              cpu,
  dmem_arbiter_if.slave              ldr,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DMEM_DATA_WIDTH-1:0] mem_wdata,
  input  logic [DMEM_DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [DMEM_CNT_WIDTH-1:0] LAT_M1 = DMEM_CNT_WIDTH'(MEM_LATENCY - 1);
  localparam bit SINGLE_CYCLE = (MEM_LATENCY == 1);

  dmem_state_t                state_r, state_nx;
  logic [DMEM_CNT_WIDTH-1:0]  cnt_r, cnt_nx;
  dmem_owner_t                owner_r;
  dmem_owner_t                grant_s;
  logic                       any_req_s;
  logic                       accept_s;

  logic                       sel_we_s;
  logic [DMEM_DATA_WIDTH-1:0] sel_addr_s;
  logic [DMEM_DATA_WIDTH-1:0] sel_wdata_s;

  logic                       mem_en_r, mem_we_r;
  logic [ADDR_WIDTH-1:0]      mem_addr_r;
  logic [DMEM_DATA_WIDTH-1:0] mem_wdata_r;
  logic                       cpu_done_r, ldr_done_r;
  logic [DMEM_DATA_WIDTH-1:0] cpu_rdata_r, ldr_rdata_r;
  logic                       fin_cpu_s, fin_ldr_s;

  rr_arbiter2 u_rr (
    .CLK     (CLK),
    .reset   (reset),
    .req_cpu (cpu.req),
    .req_ldr (ldr.req),
    .accept  (accept_s),
    .grant   (grant_s),
    .any_req (any_req_s)
  );

  // Route the winning requester's transaction towards the memory latches.
  always_comb begin
    sel_we_s    = cpu.we;
    sel_addr_s  = cpu.addr;
    sel_wdata_s = cpu.wdata;
    if (grant_s == OWN_LDR) begin
      sel_we_s    = ldr.we;
      sel_addr_s  = ldr.addr;
      sel_wdata_s = ldr.wdata;
    end else begin
      sel_we_s    = cpu.we;
      sel_addr_s  = cpu.addr;
      sel_wdata_s = cpu.wdata;
    end
  end

  // Next-state logic: grant in IDLE, strobe in ISSUE, count out the latency.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          accept_s = 1'b1;
          state_nx = ISSUE;
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        cnt_nx = LAT_M1;
        if (SINGLE_CYCLE) begin
          state_nx = DONE;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt_r <= 3'd1) begin
          state_nx = DONE;
        end else begin
          cnt_nx   = cnt_r - 3'd1;
          state_nx = WAIT;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Which requester finishes at the coming edge (drives its done/rdata).
  always_comb begin
    fin_cpu_s = 1'b0;
    fin_ldr_s = 1'b0;
    if (state_nx == DONE) begin
      fin_cpu_s = (owner_r == OWN_CPU);
      fin_ldr_s = (owner_r == OWN_LDR);
    end else begin
      fin_cpu_s = 1'b0;
      fin_ldr_s = 1'b0;
    end
  end

  // State and latency counter registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
    end
  end

  // Registered outputs; the memory-side fields are latched at grant and
  // held until the next grant so they stay stable from ISSUE through DONE.
  always_ff @(posedge CLK) begin
    if (reset) begin
      owner_r     <= OWN_CPU;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h0;
      cpu_done_r  <= 1'b0;
      ldr_done_r  <= 1'b0;
      cpu_rdata_r <= 32'h0;
      ldr_rdata_r <= 32'h0;
    end else begin
      mem_en_r   <= (state_nx == ISSUE);
      cpu_done_r <= fin_cpu_s;
      ldr_done_r <= fin_ldr_s;
      if (accept_s) begin
        owner_r     <= grant_s;
        mem_we_r    <= sel_we_s;
        mem_addr_r  <= sel_addr_s[ADDR_WIDTH+1:2];
        mem_wdata_r <= sel_wdata_s;
      end
      if (fin_cpu_s) begin
        cpu_rdata_r <= mem_rdata;
      end
      if (fin_ldr_s) begin
        ldr_rdata_r <= mem_rdata;
      end
    end
  end

  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign cpu.done  = cpu_done_r;
  assign cpu.rdata = cpu_rdata_r;
  assign ldr.done  = ldr_done_r;
  assign ldr.rdata = ldr_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter: a latency-2 instance
// with two random requesters and a latency-1 instance doing back-to-back
// cpu accesses, both checked against a transaction-level reference model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW  = 17;
  localparam int LAT = 2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } txn_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- latency-2 instance ----------------
  logic              reset;
  logic              mem_en, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  dmem_arbiter_if    cpu_if();
  dmem_arbiter_if    ldr_if();

  dmem_arbiter #(.ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) u_dut (
    .CLK(CLK), .reset(reset), .cpu(cpu_if), .ldr(ldr_if),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory stand-in: the word addressed at mem_en is presented for one cycle
  // only, so it is sampled at the second edge counted from the mem_en edge.
  logic [31:0] mem_arr [0:(1<<AW)-1] = '{4: 32'hDEAD_BEEF, default: 32'h0};
  logic [31:0] rd_q = 32'h0;
  always @(posedge CLK) begin
    if (mem_en) begin
      rd_q <= mem_arr[mem_addr];
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
    end else begin
      rd_q <= 32'hA5A5_A5A5;
    end
  end
  assign mem_rdata = rd_q;

  // Reference model state.
  logic [31:0] model_mem [int];
  txn_t        scr0[$];
  txn_t        scr1[$];
  bit          act[2];
  txn_t        cur[2];
  int          done_at[2];

  function automatic logic [31:0] mread(input int a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  function automatic txn_t gen_txn(input int w);
    txn_t t;
    if (w == 0 && scr0.size() > 0) begin
      t = scr0.pop_front();
    end else if (w == 1 && scr1.size() > 0) begin
      t = scr1.pop_front();
    end else begin
      t.we   = 1'($urandom_range(0, 1));
      t.addr = ($urandom() & 32'hFFF8_0000) | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3));
      t.wd   = $urandom();
    end
    return t;
  endfunction

  task automatic apply();
    cpu_if.req = act[0]; cpu_if.we = cur[0].we; cpu_if.addr = cur[0].addr; cpu_if.wdata = cur[0].wd;
    ldr_if.req = act[1]; ldr_if.we = cur[1].we; ldr_if.addr = cur[1].addr; ldr_if.wdata = cur[1].wd;
  endtask

  // ---------------- latency-1 instance ----------------
  logic              reset1;
  logic              mem_en1, mem_we1;
  logic [AW-1:0]     mem_addr1;
  logic [31:0]       mem_wdata1, mem_rdata1;
  dmem_arbiter_if    cpu1_if();
  dmem_arbiter_if    ldr1_if();
  bit                l1_fin = 1'b0;

  dmem_arbiter #(.ADDR_WIDTH(AW), .MEM_LATENCY(1)) u_dut1 (
    .CLK(CLK), .reset(reset1), .cpu(cpu1_if), .ldr(ldr1_if),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  logic [31:0] mem1_arr [0:15] = '{default: 32'h0};
  always @(posedge CLK) begin
    if (mem_en1 && mem_we1) mem1_arr[mem_addr1[3:0]] <= mem_wdata1;
  end
  assign mem_rdata1 = mem1_arr[mem_addr1[3:0]];

  // Back-to-back cpu traffic on the latency-1 instance.
  initial begin
    logic [31:0] model1 [16];
    bit          pend1, a1, we1;
    int          iss1, don1, free1, done1, idx1;
    logic [31:0] wd1, exp1;
    for (int i = 0; i < 16; i++) model1[i] = 32'h0;
    pend1 = 1'b0; a1 = 1'b0; we1 = 1'b0; iss1 = -10; don1 = -10; free1 = 0; done1 = -10;
    idx1 = 0; wd1 = 32'h0; exp1 = 32'h0;
    reset1 = 1'b1;
    cpu1_if.req = 1'b0; cpu1_if.we = 1'b0; cpu1_if.addr = 32'h0; cpu1_if.wdata = 32'h0;
    ldr1_if.req = 1'b0; ldr1_if.we = 1'b0; ldr1_if.addr = 32'h0; ldr1_if.wdata = 32'h0;
    repeat (3) @(posedge CLK);
    #2;
    check_eq("l1_rst_done", 32'(cpu1_if.done), 32'h0);
    check_eq("l1_rst_en", 32'(mem_en1), 32'h0);
    reset1 = 1'b0;
    for (int c = 0; c < 150; c++) begin
      check_eq("l1_mem_en", 32'(mem_en1), 32'(pend1 && c == iss1));
      if (pend1 && c == iss1) begin
        check_eq("l1_mem_addr", 32'(mem_addr1), 32'(idx1));
        check_eq("l1_mem_we", 32'(mem_we1), 32'(we1));
      end
      check_eq("l1_cpu_done", 32'(cpu1_if.done), 32'(pend1 && c == don1));
      check_eq("l1_ldr_done", 32'(ldr1_if.done), 32'h0);
      if (pend1 && c == don1) begin
        if (!we1) check_eq("l1_rdata", cpu1_if.rdata, exp1);
        done1 = c; pend1 = 1'b0; free1 = c + 1;
      end
      if (a1 && done1 == c - 1) a1 = 1'b0;
      if (!a1) begin
        a1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        idx1 = $urandom_range(0, 15); wd1 = $urandom();
      end
      if (!pend1 && c >= free1 && a1) begin
        iss1 = c + 1; don1 = c + 2; pend1 = 1'b1;
        if (we1) model1[idx1] = wd1;
        else exp1 = model1[idx1];
      end
      cpu1_if.req = a1; cpu1_if.we = we1; cpu1_if.addr = 32'(idx1) << 2; cpu1_if.wdata = wd1;
      @(posedge CLK);
      #2;
    end
    l1_fin = 1'b1;
  end

  // Main sequence for the latency-2 instance.
  initial begin
    bit          pend, last_ldr, rst_done, rst_pending;
    int          own, iss_c, don_c, free_c, pct;
    logic        e_we;
    logic [31:0] e_addr, e_wd, e_rd;

    pend = 1'b0; last_ldr = 1'b1; rst_done = 1'b0; rst_pending = 1'b0;
    own = 0; iss_c = -10; don_c = -10; free_c = 0;
    e_we = 1'b0; e_addr = 32'h0; e_wd = 32'h0; e_rd = 32'h0;
    model_mem[4] = 32'hDEAD_BEEF;
    for (int w = 0; w < 2; w++) begin
      act[w] = 1'b0; cur[w] = '0; done_at[w] = -10;
    end
    scr0.push_back('{1'b0, 32'h0000_0010, 32'h0});
    scr0.push_back('{1'b0, 32'h0000_0020, 32'h0});
    scr0.push_back('{1'b0, 32'h0008_0004, 32'h0});
    scr1.push_back('{1'b1, 32'h0000_0020, 32'h1234_5678});

    reset = 1'b1;
    apply();
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_mem_en", 32'(mem_en), 32'h0);
    check_eq("rst_mem_we", 32'(mem_we), 32'h0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_cpu_done", 32'(cpu_if.done), 32'h0);
    check_eq("rst_ldr_done", 32'(ldr_if.done), 32'h0);
    check_eq("rst_cpu_rdata", cpu_if.rdata, 32'h0);
    check_eq("rst_ldr_rdata", ldr_if.rdata, 32'h0);
    reset = 1'b0;

    for (int c = 0; c < 900; c++) begin
      if (rst_pending) begin
        check_eq("abort_mem_addr", 32'(mem_addr), 32'h0);
        check_eq("abort_cpu_rdata", cpu_if.rdata, 32'h0);
        check_eq("abort_ldr_rdata", ldr_if.rdata, 32'h0);
        rst_pending = 1'b0;
      end
      check_eq("mem_en", 32'(mem_en), 32'(pend && c == iss_c));
      if (pend && c == iss_c) begin
        check_eq("mem_addr", 32'(mem_addr), e_addr);
        check_eq("mem_we", 32'(mem_we), 32'(e_we));
        if (e_we) check_eq("mem_wdata", mem_wdata, e_wd);
      end
      if (pend && c > iss_c && c <= don_c) check_eq("mem_addr_hold", 32'(mem_addr), e_addr);
      check_eq("cpu_done", 32'(cpu_if.done), 32'(pend && c == don_c && own == 0));
      check_eq("ldr_done", 32'(ldr_if.done), 32'(pend && c == don_c && own == 1));
      if (pend && c == don_c) begin
        if (!e_we) check_eq(own == 0 ? "cpu_rdata" : "ldr_rdata",
                            own == 0 ? cpu_if.rdata : ldr_if.rdata, e_rd);
        done_at[own] = c; pend = 1'b0; free_c = c + 1;
      end

      // Abort one cpu read while it is waiting on memory.
      reset = 1'b0;
      if (!rst_done && c > 600 && pend && own == 0 && !e_we && c == iss_c + 1) begin
        reset = 1'b1; rst_done = 1'b1; rst_pending = 1'b1;
        pend = 1'b0; last_ldr = 1'b1; free_c = c + 1;
      end

      pct = (c < 300) ? 40 : ((c < 600) ? 100 : 60);
      for (int w = 0; w < 2; w++) begin
        if (act[w] && done_at[w] == c - 1) act[w] = 1'b0;
        if (!act[w] && ((w == 0 && scr0.size() > 0) || (w == 1 && scr1.size() > 0) ||
                        $urandom_range(0, 99) < pct)) begin
          act[w] = 1'b1; cur[w] = gen_txn(w);
        end
      end

      if (!reset && !pend && c >= free_c && (act[0] || act[1])) begin
        if (act[0] && act[1]) own = last_ldr ? 0 : 1;
        else own = act[1] ? 1 : 0;
        last_ldr = (own == 1);
        iss_c = c + 1; don_c = c + 1 + LAT; pend = 1'b1;
        e_we = cur[own].we; e_wd = cur[own].wd;
        e_addr = 32'(cur[own].addr[AW+1:2]);
        if (e_we) model_mem[int'(e_addr)] = e_wd;
        else e_rd = mread(int'(e_addr));
      end

      apply();
      @(posedge CLK);
      #1;
    end

    check_eq("abort_injected", 32'(rst_done), 32'h1);
    for (int i = 0; i < 1000 && !l1_fin; i++) @(posedge CLK);
    check_eq("l1_finished", 32'(l1_fin), 32'h1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
